mux_2x1_arbiter: RTL and testbench

Round-robin arbiter that shares one registered 2:1 output channel between two valid/ready requesters. It owns the select line of the shared 2:1 mux and sequences grants per packet, with a beat limit that forces rotation when both sides are busy. It sits in front of any single-consumer datapath fed by two producers.

---
 rtl/mux_2x1_arbiter.sv | 86 ++++++++
 tb/tb_mux_2x1_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_arbiter: round-robin packet arbiter driving a registered 2:1 output channel
module mux_2x1_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_last,
   output logic             in1_ready,
   input  logic             in2_valid,
   input  logic [WIDTH-1:0] in2_data,
   input  logic             in2_last,
   output logic             in2_ready,
   output logic             y_valid,
   output logic [WIDTH-1:0] y_data,
   output logic             y_last,
   input  logic             y_ready,
   output logic             sel,
   output logic             busy
);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);
   typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;
   state_t state, state_nxt;
   logic prio, prio_nxt, sel_nxt, own2, cur_valid, cur_last, oth_valid, rdy, xfer, at_limit, rel;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] cur_data;
   // grant decode, handshake and next-state; cnt saturates at MAX_HOLD-1 so the limit stays armed
   always_comb begin
      own2      = state == OWN2;
      cur_valid = own2 ? in2_valid : in1_valid;
      cur_last  = own2 ? in2_last : in1_last;
      cur_data  = own2 ? in2_data : in1_data;
      oth_valid = own2 ? in1_valid : in2_valid;
      rdy       = (state != IDLE) && (!y_valid || y_ready);
      in1_ready = (state == OWN1) && rdy;
      in2_ready = own2 && rdy;
      xfer      = cur_valid && rdy;
      at_limit  = cnt == LIM;
      rel       = xfer && (cur_last || (at_limit && oth_valid));
      state_nxt = state;
      prio_nxt  = prio;
      cnt_nxt   = cnt;
      if (state == IDLE)
         state_nxt = (in1_valid && in2_valid) ? (prio ? OWN2 : OWN1) :
                     in1_valid ? OWN1 : in2_valid ? OWN2 : IDLE;
      else if (rel) begin
         state_nxt = oth_valid ? (own2 ? OWN1 : OWN2) : IDLE;
         prio_nxt  = !own2;
         cnt_nxt   = '0;
      end else if (xfer)
         cnt_nxt = at_limit ? cnt : cnt + CW'(1);
      sel_nxt = (state_nxt == OWN2) ? 1'b1 : (state_nxt == OWN1) ? 1'b0 : sel;
   end
   // arbitration state, priority pointer, beat counter and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         prio  <= 1'b0;
         cnt   <= '0;
         sel   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         cnt   <= cnt_nxt;
         sel   <= sel_nxt;
         busy  <= state_nxt != IDLE;
      end
   end
   // output register stage: load on transfer, drain when consumed without a new beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_last  <= 1'b0;
      end else if (xfer) begin
         y_valid <= 1'b1;
         y_data  <= cur_data;
         y_last  <= cur_last;
      end else if (y_ready)
         y_valid <= 1'b0;
   end
endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// tb_mux_2x1_arbiter: directed and randomized checks against a cycle-level reference model
module tb_mux_2x1_arbiter;
   localparam int W  = 8;
   localparam int MH = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in1_valid = 0, in1_last = 0, in2_valid = 0, in2_last = 0, y_ready = 0;
   logic [W-1:0] in1_data = '0, in2_data = '0;
   logic in1_ready, in2_ready, y_valid, y_last, sel, busy;
   logic [W-1:0] y_data;
   int checks = 0, errors = 0;
   int own, prio, beats;
   logic m_yv, m_yl, m_sel;
   logic [W-1:0] m_yd;
   int rem [2];
   logic offer [2];
   logic [W-1:0] od [2];
   logic a1, a2;

   always #5 clk = ~clk;

   mux_2x1_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
      .in2_valid(in2_valid), .in2_data(in2_data), .in2_last(in2_last), .in2_ready(in2_ready),
      .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
      .sel(sel), .busy(busy)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      own = 0; prio = 0; beats = 0;
      m_yv = 0; m_yl = 0; m_yd = '0; m_sel = 0;
      for (int k = 0; k < 2; k++) begin rem[k] = 0; offer[k] = 0; od[k] = '0; end
   endtask

   task automatic step(input logic v1, input logic [W-1:0] d1, input logic l1,
                       input logic v2, input logic [W-1:0] d2, input logic l2,
                       input logic yr, output logic acc1, output logic acc2);
      logic rdy, x, rel, cv, cl, ov;
      logic [W-1:0] cd;
      int nown;
      @(negedge clk);
      in1_valid = v1; in1_data = d1; in1_last = l1;
      in2_valid = v2; in2_data = d2; in2_last = l2;
      y_ready = yr;
      #1;
      rdy = (own != 0) && (!m_yv || yr);
      chk("in1_ready", in1_ready, (own == 1) && rdy);
      chk("in2_ready", in2_ready, (own == 2) && rdy);
      chk("y_valid", y_valid, m_yv);
      if (m_yv) begin
         chk("y_data", y_data, m_yd);
         chk("y_last", y_last, m_yl);
      end
      chk("sel", sel, m_sel);
      chk("busy", busy, own != 0);
      cv = (own == 2) ? v2 : v1;
      cl = (own == 2) ? l2 : l1;
      cd = (own == 2) ? d2 : d1;
      ov = (own == 2) ? v1 : v2;
      x = (own != 0) && cv && rdy;
      acc1 = x && own == 1;
      acc2 = x && own == 2;
      nown = own;
      rel = x && (cl || (beats + 1 >= MH && ov));
      if (own == 0)
         nown = (v1 && v2) ? prio + 1 : v1 ? 1 : v2 ? 2 : 0;
      if (x) begin m_yv = 1; m_yd = cd; m_yl = cl; beats++; end
      else if (yr) m_yv = 0;
      if (rel) begin
         prio = 2 - own;
         beats = 0;
         nown = ov ? 3 - own : 0;
      end
      if (nown != 0) m_sel = (nown == 2);
      own = nown;
   endtask

   task automatic run(input int n, input int p1, input int p2, input int len1, input int len2, input int pyr);
      int p [2], len [2];
      p[0] = p1; p[1] = p2; len[0] = len1; len[1] = len2;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 2; k++)
            if (!offer[k] && $urandom_range(99) < p[k]) begin
               if (rem[k] == 0) rem[k] = len[k] != 0 ? len[k] : $urandom_range(1, 6);
               offer[k] = 1;
               od[k] = W'($urandom);
            end
         step(offer[0], od[0], rem[0] == 1, offer[1], od[1], rem[1] == 1,
              $urandom_range(99) < pyr, a1, a2);
         if (a1) begin offer[0] = 0; rem[0]--; end
         if (a2) begin offer[1] = 0; rem[1]--; end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_y_valid"}, y_valid, 0);
      chk({tag, "_y_data"}, y_data, 0);
      chk({tag, "_sel"}, sel, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_in1_ready"}, in1_ready, 0);
      chk({tag, "_in2_ready"}, in2_ready, 0);
   endtask

   initial begin
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 1, 8'hA1, 0, 1, a1, a2);
      step(0, 0, 0, 1, 8'hA1, 0, 1, a1, a2);
      chk("single_acc_a1", a2, 1);
      step(0, 0, 0, 1, 8'hA2, 0, 1, a1, a2);
      step(0, 0, 0, 1, 8'hA3, 1, 1, a1, a2);
      step(0, 0, 0, 0, 8'h00, 0, 1, a1, a2);
      chk("single_y_a3", y_data, 8'hA3);
      chk("single_y_last", y_last, 1);
      step(0, 0, 0, 0, 8'h00, 0, 1, a1, a2);
      chk("single_sel_holds", sel, 1);
      chk("single_idle", busy, 0);
      run(16, 100, 100, 2, 2, 100);
      run(40, 100, 100, 10, 10, 100);
      run(40, 100, 100, 0, 0, 40);
      run(40, 60, 100, 6, 3, 80);
      for (int i = 0; i < 60 && own != 2; i++) run(1, 100, 100, 10, 10, 100);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      in1_valid = 0; in2_valid = 0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 8'h11, 1, 1, 8'h22, 1, 1, a1, a2);
      step(1, 8'h11, 1, 1, 8'h22, 1, 1, a1, a2);
      chk("reset_in1_first", a1, 1);
      run(400, 70, 70, 0, 0, 70);
      run(200, 100, 100, 0, 0, 50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
